// File: rtl/polar_pkg.sv
// Shared types and elaboration-time helpers for the iterative polar encoder.
// The functions are evaluated only on constants (parameters and genvars).
package polar_pkg;

    localparam int MAX_N    = 1024;
    localparam int MAX_LOG2 = 10;

    typedef enum logic [1:0] {
        IDLE,
        ENC,
        OUT
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

    function automatic int bitrev(input int idx, input int bits);
        int r;
        r = 0;
        for (int b = 0; b < bits; b++) begin
            r = r | (((idx >> b) & 1) << (bits - 1 - b));
        end
        return r;
    endfunction

    // Counts set bits among the lowest n positions of v.
    function automatic int popcount(input logic [MAX_N-1:0] v, input int n);
        int c;
        c = 0;
        for (int b = 0; b < n; b++) begin
            if (v[b[MAX_LOG2-1:0]]) begin
                c++;
            end
        end
        return c;
    endfunction

    function automatic int zeros_below(input logic [MAX_N-1:0] mask, input int idx);
        return idx - popcount(mask, idx);
    endfunction

endpackage

// File: rtl/polar_bfly_stage.sv
// One Arikan butterfly stage, selected at run time by stage_i.
// Every stage is built from constant wiring; the stage index only steers the final mux.
module polar_bfly_stage
    import polar_pkg::*;
#(
    parameter int N  = 8,
    parameter int SW = 3
) (
    input  logic [N-1:0]  u_i,
    input  logic [SW-1:0] stage_i,
    output logic [N-1:0]  u_o
);

    localparam int LOG2N   = clog2(N);
    localparam int NSLOTS  = 2 ** SW;

    logic [N-1:0] stage_res [NSLOTS];

    // Unused slots beyond LOG2N-1 pass the vector through unchanged.
    for (genvar s = 0; s < NSLOTS; s++) begin : g_stage
        for (genvar i = 0; i < N; i++) begin : g_bit
            if (s < LOG2N && ((i >> s) & 1) == 0) begin : g_xor
                assign stage_res[s][i] = u_i[i] ^ u_i[i + (1 << s)];
            end else begin : g_pass
                assign stage_res[s][i] = u_i[i];
            end
        end
    end

    assign u_o = stage_res[stage_i];

endmodule

// File: rtl/polar_encoder_iter.sv
// Sequential polar encoder: one frame in, LOG2N butterfly stages, one codeword out.
// Define POLAR_BITREV_OUT_EN to present the codeword in bit-reversed index order.
module polar_encoder_iter
    import polar_pkg::*;
#(
    parameter int           N           = 8,
    parameter int           K           = 4,
    parameter logic [N-1:0] FROZEN_MASK = 8'h17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [K-1:0] data_i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] code_o
);

    localparam int               LOG2N      = clog2(N);
    localparam int               SW         = clog2(LOG2N) + 1;
    localparam logic [MAX_N-1:0] MASK_EXT   = MAX_N'(FROZEN_MASK);
    localparam logic [SW-1:0]    LAST_STAGE = SW'(LOG2N - 1);

    if (N < 4 || N > MAX_N || (1 << LOG2N) != N) begin : g_bad_n
        $error("polar_encoder_iter: N=%0d must be a power of two in 4..1024", N);
    end
    if (popcount(MASK_EXT, N) != N - K) begin : g_bad_k
        $error("polar_encoder_iter: K=%0d does not match the %0d unfrozen mask bits",
               K, N - popcount(MASK_EXT, N));
    end

    state_e        state_q, state_d;
    logic [N-1:0]  u_q, u_d;
    logic [SW-1:0] stage_q, stage_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [N-1:0]  code_q, code_d;
    logic [N-1:0]  u_load;
    logic [N-1:0]  u_bfly;

    // Info bit j lands on the j-th unfrozen index, counted upward from 0.
    for (genvar i = 0; i < N; i++) begin : g_map
        localparam int J = zeros_below(MASK_EXT, i);
        if (FROZEN_MASK[i] || J >= K) begin : g_frozen
            assign u_load[i] = 1'b0;
        end else begin : g_info
            assign u_load[i] = data_i[J];
        end
    end

    polar_bfly_stage #(
        .N  (N),
        .SW (SW)
    ) u_bfly_stage (
        .u_i     (u_q),
        .stage_i (stage_q),
        .u_o     (u_bfly)
    );

    always_comb begin
        state_d = state_q;
        u_d     = u_q;
        stage_d = stage_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    u_d     = u_load;
                    stage_d = '0;
                    state_d = ENC;
                end
            end
            ENC: begin
                u_d = u_bfly;
                if (stage_q == LAST_STAGE) begin
                    stage_d = '0;
                    state_d = OUT;
                end else begin
                    stage_d = stage_q + 1'b1;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == OUT);
        code_d      = (state_d == OUT) ? u_d : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            u_q         <= '0;
            stage_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            code_q      <= '0;
        end else begin
            state_q     <= state_d;
            u_q         <= u_d;
            stage_q     <= stage_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            code_q      <= code_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;

`ifdef POLAR_BITREV_OUT_EN
    for (genvar i = 0; i < N; i++) begin : g_bitrev
        assign code_o[bitrev(i, LOG2N)] = code_q[i];
    end
`else
    assign code_o = code_q;
`endif

endmodule

// File: tb/tb_polar_encoder_iter.sv
// Scoreboard bench for polar_encoder_iter: directed N=8 cases plus random traffic
// on N=8/16/64/1024 encoders, checked against a superset-XOR reference model.
module tb_polar_encoder_iter;

   // Random frozen masks; the top index is always left as an info bit.
   function automatic logic [1023:0] mk_mask(input int n, input int seed);
      bit [31:0]     s;
      logic [1023:0] m;
      int            t;
      s = seed;
      m = '0;
      for (int i = 0; i < n; i++) begin
         s = s * 32'd1103515245 + 32'd12345;
         m[i[9:0]] = s[20];
      end
      t = n - 1;
      m[t[9:0]] = 1'b0;
      return m;
   endfunction

   function automatic int count_zeros(input logic [1023:0] m, input int n);
      int c;
      c = 0;
      for (int i = 0; i < n; i++) begin
         if (!m[i[9:0]]) c++;
      end
      return c;
   endfunction

   localparam int            N0 = 8;
   localparam int            K0 = 4;
   localparam logic [1023:0] M0 = 1024'h17;
   localparam int            N1 = 64;
   localparam logic [1023:0] M1 = mk_mask(64, 11);
   localparam int            K1 = count_zeros(M1, 64);
   localparam int            N2 = 1024;
   localparam logic [1023:0] M2 = mk_mask(1024, 77);
   localparam int            K2 = count_zeros(M2, 1024);
   localparam int            N3 = 16;
   localparam logic [1023:0] M3 = mk_mask(16, 5);
   localparam int            K3 = count_zeros(M3, 16);

`ifdef POLAR_BITREV_OUT_EN
   localparam logic [7:0] EXP_0001 = 8'h55;
`else
   localparam logic [7:0] EXP_0001 = 8'h0F;
`endif
   localparam logic [7:0] EXP_1000 = 8'hFF;
   localparam logic [7:0] EXP_1111 = 8'h96;
   localparam logic [7:0] EXP_0000 = 8'h00;

   logic          clk;
   logic          rst0_n;
   logic          rsto_n;
   logic          iv   [4];
   logic          ordy [4];
   bit            rnd  [4];
   logic [1023:0] dw   [4];

   wire           ir0, ir1, ir2, ir3;
   wire           ov0, ov1, ov2, ov3;
   wire [N0-1:0]  c0;
   wire [N1-1:0]  c1;
   wire [N2-1:0]  c2;
   wire [N3-1:0]  c3;

   int            checks;
   int            errors;
   logic [1023:0] exp_q [4][$];

   polar_encoder_iter #(.N(N0), .K(K0), .FROZEN_MASK(M0[N0-1:0])) dut0 (
      .clk(clk), .rst_n(rst0_n), .in_valid(iv[0]), .in_ready(ir0), .data_i(dw[0][K0-1:0]),
      .out_valid(ov0), .out_ready(ordy[0]), .code_o(c0));
   polar_encoder_iter #(.N(N1), .K(K1), .FROZEN_MASK(M1[N1-1:0])) dut1 (
      .clk(clk), .rst_n(rsto_n), .in_valid(iv[1]), .in_ready(ir1), .data_i(dw[1][K1-1:0]),
      .out_valid(ov1), .out_ready(ordy[1]), .code_o(c1));
   polar_encoder_iter #(.N(N2), .K(K2), .FROZEN_MASK(M2[N2-1:0])) dut2 (
      .clk(clk), .rst_n(rsto_n), .in_valid(iv[2]), .in_ready(ir2), .data_i(dw[2][K2-1:0]),
      .out_valid(ov2), .out_ready(ordy[2]), .code_o(c2));
   polar_encoder_iter #(.N(N3), .K(K3), .FROZEN_MASK(M3[N3-1:0])) dut3 (
      .clk(clk), .rst_n(rsto_n), .in_valid(iv[3]), .in_ready(ir3), .data_i(dw[3][K3-1:0]),
      .out_valid(ov3), .out_ready(ordy[3]), .code_o(c3));

   // Free-running 100 MHz clock shared by all encoders.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int get_n(input int k);
      case (k)
         0: return N0;
         1: return N1;
         2: return N2;
         default: return N3;
      endcase
   endfunction

   function automatic logic [1023:0] get_mask(input int k);
      case (k)
         0: return M0;
         1: return M1;
         2: return M2;
         default: return M3;
      endcase
   endfunction

   function automatic logic get_ready(input int k);
      case (k)
         0: return ir0;
         1: return ir1;
         2: return ir2;
         default: return ir3;
      endcase
   endfunction

   function automatic logic get_valid(input int k);
      case (k)
         0: return ov0;
         1: return ov1;
         2: return ov2;
         default: return ov3;
      endcase
   endfunction

   function automatic logic [1023:0] get_code(input int k);
      case (k)
         0: return 1024'(c0);
         1: return 1024'(c1);
         2: return 1024'(c2);
         default: return 1024'(c3);
      endcase
   endfunction

   function automatic int tb_bitrev(input int idx, input int bits);
      int r;
      r = 0;
      for (int b = 0; b < bits; b++) r = r | (((idx >> b) & 1) << (bits - 1 - b));
      return r;
   endfunction

   // Reference: place info bits, then x_i = XOR of u_j over every superset j of i.
   function automatic logic [1023:0] ref_encode(input logic [1023:0] d, input logic [1023:0] m,
                                                input int n);
      logic [1023:0] u, x, r;
      int            j, lg, bi;
      bit            p;
      u = '0; x = '0; r = '0; j = 0; lg = 0;
      while ((1 << lg) < n) lg++;
      for (int i = 0; i < n; i++) begin
         if (!m[i[9:0]]) begin
            u[i[9:0]] = d[j[9:0]];
            j++;
         end
      end
      for (int i = 0; i < n; i++) begin
         p = 1'b0;
         for (int s = i; s < n; s = (s + 1) | i) p = p ^ u[s[9:0]];
         x[i[9:0]] = p;
      end
`ifdef POLAR_BITREV_OUT_EN
      for (int i = 0; i < n; i++) begin
         bi = tb_bitrev(i, lg);
         r[bi[9:0]] = x[i[9:0]];
      end
      return r;
`else
      bi = 0;
      r = x;
      return r;
`endif
   endfunction

   function automatic logic [1023:0] rand_vec();
      logic [1023:0] v;
      for (int w = 0; w < 32; w++) v[w*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [1023:0] act,
                              input logic [1023:0] exp);
      int fd;
      checks++;
      if (act !== exp) begin
         errors++;
         fd = -1;
         for (int b = 1023; b >= 0; b--) if (act[b] !== exp[b]) fd = b;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (low 128 bits, first differing bit %0d)",
                  name, act[127:0], exp[127:0], fd);
      end
   endtask

   // Offers one frame, waits for acceptance and queues the model's codeword.
   task automatic applyStimulus(input int k, input logic [1023:0] d, input bit keep,
                                output time t_acc);
      int cnt;
      bit ok;
      dw[k] = d;
      iv[k] = 1'b1;
      cnt = 0;
      ok = 1'b0;
      t_acc = 0;
      while (!ok && cnt < 400) begin
         @(negedge clk);
         if (get_ready(k)) ok = 1'b1;
         else cnt++;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept%0d: in_ready got 0 for 400 cycles, expected 1", k);
         iv[k] = 1'b0;
         return;
      end
      exp_q[k].push_back(ref_encode(d, get_mask(k), get_n(k)));
      @(posedge clk);
      t_acc = $time;
      #1;
      dw[k] = rand_vec();
      if (!keep) iv[k] = 1'b0;
   endtask

   // Checks out_valid rises exactly on the third edge after acceptance, then the codeword.
   task automatic waitLatency(input logic [7:0] want);
      for (int e = 1; e <= 3; e++) begin
         @(posedge clk);
         #1;
         checkOutput($sformatf("latency_edge%0d", e), 1024'(ov0), 1024'(e == 3));
      end
      checkOutput("direct_code", 1024'(c0), 1024'(want));
   endtask

   task automatic randomDriver(input int k, input int frames);
      time t;
      for (int f = 0; f < frames; f++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         applyStimulus(k, rand_vec(), 1'b0, t);
      end
   endtask

   // Randomised out_ready, changed just after the active edge.
   always @(posedge clk) begin
      #2;
      for (int k = 0; k < 4; k++) if (rnd[k]) ordy[k] = 1'($urandom_range(0, 1));
   end

   // Monitor: every transfer seen before an edge is compared with the oldest expectation.
   always @(negedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (get_valid(k) && ordy[k]) begin
            if (exp_q[k].size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL codeword%0d: got 0x%0h with no frame outstanding, expected none",
                        k, get_code(k));
            end else begin
               checkOutput($sformatf("codeword%0d", k), get_code(k), exp_q[k].pop_front());
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios on the N=8 encoder, then random traffic on all four.
   initial begin
      time t, tprev;
      int  cnt;
      bit  drained;
      checks = 0;
      errors = 0;
      for (int k = 0; k < 4; k++) begin
         iv[k] = 1'b0;
         ordy[k] = 1'b0;
         rnd[k] = 1'b0;
         dw[k] = '0;
      end
      rst0_n = 1'b0;
      rsto_n = 1'b0;
      #3;
      checkOutput("reset_in_ready", 1024'(ir0), 1024'(0));
      checkOutput("reset_out_valid", 1024'(ov0), 1024'(0));
      checkOutput("reset_code", 1024'(c0), 1024'(0));
      repeat (2) @(negedge clk);
      rst0_n = 1'b1;
      rsto_n = 1'b1;
      ordy[0] = 1'b1;

      $display("[TB] directed frames");
      applyStimulus(0, 1024'b0001, 1'b0, t);
      waitLatency(EXP_0001);
      applyStimulus(0, 1024'b1000, 1'b0, t);
      waitLatency(EXP_1000);
      applyStimulus(0, 1024'b1111, 1'b0, t);
      waitLatency(EXP_1111);
      applyStimulus(0, 1024'b0000, 1'b0, t);
      waitLatency(EXP_0000);

      $display("[TB] backpressure");
      @(posedge clk);
      #1;
      ordy[0] = 1'b0;
      applyStimulus(0, 1024'b1111, 1'b0, t);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("bp_valid_rise", 1024'(ov0), 1024'(1));
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         iv[0] = c[0];
         dw[0] = rand_vec();
         @(negedge clk);
         checkOutput("bp_hold_code", 1024'(c0), 1024'(EXP_1111));
         checkOutput("bp_hold_valid", 1024'(ov0), 1024'(1));
         checkOutput("bp_in_ready", 1024'(ir0), 1024'(0));
      end
      @(posedge clk);
      #1;
      iv[0] = 1'b0;
      ordy[0] = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("bp_release_in_ready", 1024'(ir0), 1024'(1));
      checkOutput("bp_release_valid", 1024'(ov0), 1024'(0));

      $display("[TB] reset during encoding");
      applyStimulus(0, 1024'b1000, 1'b0, t);
      @(posedge clk);
      #1;
      rst0_n = 1'b0;
      #1;
      void'(exp_q[0].pop_back());
      checkOutput("midreset_valid", 1024'(ov0), 1024'(0));
      checkOutput("midreset_code", 1024'(c0), 1024'(0));
      checkOutput("midreset_in_ready", 1024'(ir0), 1024'(0));
      repeat (2) @(negedge clk);
      rst0_n = 1'b1;
      applyStimulus(0, 1024'b0001, 1'b0, t);
      waitLatency(EXP_0001);

      $display("[TB] back-to-back frames");
      tprev = 0;
      for (int f = 0; f < 5; f++) begin
         applyStimulus(0, 1024'($urandom_range(0, 15)), f < 4, t);
         if (f > 0) checkOutput("throughput_gap", 1024'(t - tprev), 1024'(50));
         tprev = t;
      end

      $display("[TB] random traffic");
      for (int k = 0; k < 4; k++) rnd[k] = 1'b1;
      fork
         randomDriver(0, 30);
         randomDriver(1, 25);
         randomDriver(2, 12);
         randomDriver(3, 30);
      join
      @(posedge clk);
      for (int k = 0; k < 4; k++) rnd[k] = 1'b0;
      #3;
      for (int k = 0; k < 4; k++) ordy[k] = 1'b1;
      cnt = 0;
      drained = 1'b0;
      while (!drained && cnt < 200) begin
         @(posedge clk);
         cnt++;
         drained = 1'b1;
         for (int k = 0; k < 4; k++) if (exp_q[k].size() != 0) drained = 1'b0;
      end
      for (int k = 0; k < 4; k++)
         checkOutput($sformatf("drain%0d", k), 1024'(exp_q[k].size()), 1024'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/polar_encoder_iter.md
Name: polar_encoder_iter

Overview:
- Parametrised, sequential polar encoder: accepts one K-bit message frame over a valid/ready handshake.
- Places message bits into the non-frozen positions of an N-bit u-vector (frozen positions forced to 0).
- Runs the log2(N) Arikan butterfly stages iteratively, one stage per clock, and presents the N-bit codeword over a valid/ready handshake.
- Generalises the fixed-size combinational N=8 encoder to arbitrary power-of-two N, programmable frozen set and backpressure; sits between the message source and the downstream channel/decoder test path.

Parameters:
- N, 8, code length; power of two, 4..1024.
- K, 4, message length; must equal the count of zero bits in FROZEN_MASK (elaboration-time check, $error on mismatch).
- FROZEN_MASK, 8'h17, N-bit mask; bit i = 1 means u[i] is frozen (0); bit 0 is u-index 0.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  message frame valid
- in_ready  output  1  encoder can accept a frame
- data_i  input  K  message; data_i[j] is the j-th info bit
- out_valid  output  1  codeword valid
- out_ready  input  1  downstream accepts codeword
- code_o  output  N  codeword; code_o[i] = x_i

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=IDLE, u register=0, stage counter=0, in_ready=0 while rst_n low, out_valid=0, code_o=0.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, load u (mapping below) and go to ENC with stage=0.
  - ENC: in_ready=0. Each cycle apply butterfly stage s with span=2^s: for every i where bit s of i is 0, u[i] <= u[i]^u[i+span]; u[i+span] is unchanged. After stage LOG2N-1, go to OUT.
  - OUT: out_valid=1, code_o=u. On out_ready, go to IDLE next cycle.
- Mapping: info bit j goes to the j-th lowest u-index whose mask bit is 0, in ascending order. Frozen u-bits load as 0 regardless of data_i.
- Result: x_i = XOR of u_j over all j whose index bits are a superset of i's bits (x = u·F^{⊗n}, natural order, no bit reversal).
- Latency: out_valid rises exactly LOG2N clock edges after the accepting edge. Throughput is one frame per LOG2N+2 cycles when out_ready is held high.
- Backpressure: code_o and out_valid hold stable while out_valid && !out_ready. in_ready stays 0 until return to IDLE; no second frame is buffered.
- data_i is sampled only on the accepting edge; later changes have no effect.
- in_valid while not IDLE is ignored (no capture, no error).
- Reset mid-ENC or mid-OUT: frame discarded, all outputs return to reset values immediately.
- LOG2N = $clog2(N). The stage counter is $clog2(LOG2N)+1 bits wide and never wraps past LOG2N-1.

Optional Feature:
- Macro POLAR_BITREV_OUT_EN.
  - Defined: OUT presents code_o[bitrev(i)] = x_i, where bitrev reverses the LOG2N index bits. This is combinational reordering on the output path, with no added latency.
  - Undefined: natural order as above.

Decomposition:
- Package polar_pkg: clog2 helper, bitrev index function, popcount function for the K-vs-mask elaboration check, and the state enum {IDLE, ENC, OUT}.
- Sub-module polar_bfly_stage: combinational; inputs u[N-1:0] and the stage index, output the one-stage-updated vector. It is instantiated once and time-multiplexed by the FSM.

Test Plan:
- N=8, K=4, mask 8'h17, data_i=4'b0001 (u3=1) -> after 3 edges out_valid=1, code_o=8'h0F.
- Same config, data_i=4'b1000 (u7=1) -> code_o=8'hFF. data_i=4'b1111 -> code_o=8'h96. data_i=0 -> code_o=8'h00.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> code_o holds 8'h96, in_ready=0, in_valid pulses ignored. Release -> IDLE next cycle, in_ready=1.
- Reset mid-ENC: assert rst_n=0 at stage 1 -> out_valid=0, code_o=0 immediately. After release, a new frame with data_i=4'b0001 yields 8'h0F.
- Back-to-back frames with in_valid and out_ready held high -> one frame per 5 cycles (N=8), codewords in order. Random-regression check vs a reference model at N=16/64/1024 with random masks.
- With POLAR_BITREV_OUT_EN, data_i=4'b0001 -> code_o=8'h55; data_i=4'b1111 -> code_o=8'h96.
